// File: rtl/risac_pkg.sv
// -----------------------------------------------------------------------------
// risac_pkg
// Shared constants and types for the RISAC front end.
//   DEFAULT_XLEN      default instruction/address width
//   DEFAULT_RESET_PC  default fetch address after reset
//   fetch_entry_t     one fetched instruction as seen by the decode stage
// -----------------------------------------------------------------------------
package risac_pkg;

    localparam int unsigned DEFAULT_XLEN     = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // The decode stage consumes entries in this layout: pc, instr, fault (LSB).
    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [DEFAULT_XLEN-1:0] instr;
        logic                    fault;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/risac_sync_fifo.sv
// -----------------------------------------------------------------------------
// risac_sync_fifo
// Single-clock FIFO used as the instruction prefetch buffer.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (pointers/count only)
//   flush             empties the FIFO; a push in the same cycle lands after it
//   push, push_data   write one entry at the tail (ignored when full)
//   pop               drop the head entry (ignored when empty or flushing)
//   pop_data          head entry, valid while empty=0
//   empty, full       occupancy flags
// The storage array is deliberately left out of reset.
// -----------------------------------------------------------------------------
module risac_sync_fifo
    import risac_pkg::*;
#(
    parameter int unsigned WIDTH = FETCH_ENTRY_W,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_idx;
    logic             wr_en;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop_data = mem_q[rd_ptr_q];

    // A flush resets the pointers first, so a simultaneous push becomes the
    // only entry, stored in slot 0.  Pointers wrap naturally since DEPTH is a
    // power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_idx   = wr_ptr_q;
        wr_en    = 1'b0;
        do_push  = push && (flush || !full);
        do_pop   = pop && !empty && !flush;

        if (flush) begin
            rd_ptr_d = '0;
            wr_idx   = '0;
            wr_en    = do_push;
            wr_ptr_d = do_push ? PTR_W'(1) : '0;
            count_d  = do_push ? CNT_W'(1) : '0;
        end else begin
            if (do_push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/risac_ifetch.sv
// -----------------------------------------------------------------------------
// risac_ifetch
// Instruction fetch unit: issues word fetches on a wait-request bus and queues
// the returned words in a prefetch FIFO for the decode stage.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   oIbusAddr, oIbusRead        fetch request (address is always word aligned)
//   iIbusData, iIbusWait        fetched word, slave wait request
//   oInstr, oInstrPc            head entry word and its address
//   oInstrFault, oInstrValid    head entry is an alignment fault / is present
//   iInstrReady                 consumer takes the head entry
//   iRedirect, iRedirectPc      jump/branch/trap target
// Configuration:
//   RISAC_IFETCH_ALIGN_CHECK_EN  when defined, a misaligned redirect target
//                                queues a single fault entry and halts fetch
//                                until the next redirect; otherwise the target
//                                low bits are ignored and oInstrFault is 0.
// -----------------------------------------------------------------------------
module risac_ifetch
    import risac_pkg::*;
#(
    parameter int unsigned      XLEN     = DEFAULT_XLEN,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] oIbusAddr,
    output logic            oIbusRead,
    input  logic [XLEN-1:0] iIbusData,
    input  logic            iIbusWait,
    output logic [XLEN-1:0] oInstr,
    output logic [XLEN-1:0] oInstrPc,
    output logic            oInstrFault,
    output logic            oInstrValid,
    input  logic            iInstrReady,
    input  logic            iRedirect,
    input  logic [XLEN-1:0] iRedirectPc
);

    localparam int unsigned ENTRY_W = 2 * XLEN + 1;

    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic               pend_q, pend_d;
    logic [XLEN-1:0]    pend_pc_q, pend_pc_d;
    logic               halted;

    logic [XLEN-1:0]    redirect_pc;
    logic [XLEN-1:0]    tgt;
    logic               apply;
    logic               bus_stall;
    logic               bus_done;

    logic               fifo_flush;
    logic               fifo_push;
    logic [ENTRY_W-1:0] fifo_push_data;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_empty;
    logic               fifo_full;

    logic               unused_bits;

`ifdef RISAC_IFETCH_ALIGN_CHECK_EN
    logic               halt_q, halt_d;

    assign halted      = halt_q;
    assign redirect_pc = iRedirectPc;
    assign oInstrFault = fifo_head[0];
    assign unused_bits = 1'b0;
`else
    assign halted      = 1'b0;
    assign redirect_pc = {iRedirectPc[XLEN-1:2], 2'b00};
    assign oInstrFault = 1'b0;
    assign unused_bits = ^{iRedirectPc[1:0], fifo_head[0]};
`endif

    // A stalled request keeps its slot: nothing can push while it waits, so
    // the FIFO cannot fill and the request stays asserted until it completes.
    assign oIbusRead = !fifo_full && !halted;
    assign oIbusAddr = fetch_pc_q;
    assign bus_stall = oIbusRead && iIbusWait;
    assign bus_done  = oIbusRead && !iIbusWait;

    assign oInstrValid = !fifo_empty;
    assign oInstrPc    = fifo_head[2*XLEN:XLEN+1];
    assign oInstr      = fifo_head[XLEN:1];
    assign fifo_pop    = !fifo_empty && iInstrReady;

    // Redirects are applied immediately unless the bus is mid-request, in
    // which case the target is parked until the request completes and its
    // word is thrown away.  Applying a redirect flushes the FIFO, which also
    // overrides any pop in that cycle.
    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        pend_d         = pend_q;
        pend_pc_d      = pend_pc_q;
`ifdef RISAC_IFETCH_ALIGN_CHECK_EN
        halt_d         = halt_q;
`endif
        tgt            = redirect_pc;
        apply          = 1'b0;
        fifo_flush     = 1'b0;
        fifo_push      = 1'b0;
        fifo_push_data = {fetch_pc_q, iIbusData, 1'b0};

        if (iRedirect && !bus_stall) begin
            apply = 1'b1;
            tgt   = redirect_pc;
        end else if (iRedirect) begin
            pend_d    = 1'b1;
            pend_pc_d = redirect_pc;
        end else if (pend_q && bus_done) begin
            apply = 1'b1;
            tgt   = pend_pc_q;
        end else if (bus_done) begin
            fifo_push  = 1'b1;
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        if (apply) begin
            fifo_flush = 1'b1;
            pend_d     = 1'b0;
`ifdef RISAC_IFETCH_ALIGN_CHECK_EN
            fetch_pc_d = {tgt[XLEN-1:2], 2'b00};
            halt_d     = 1'b0;
            // The fault entry carries the full misaligned target for the trap.
            if (tgt[1:0] != 2'b00) begin
                fifo_push      = 1'b1;
                fifo_push_data = {tgt, {XLEN{1'b0}}, 1'b1};
                halt_d         = 1'b1;
            end
`else
            fetch_pc_d = tgt;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= {RESET_PC[XLEN-1:2], 2'b00};
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
`ifdef RISAC_IFETCH_ALIGN_CHECK_EN
            halt_q     <= 1'b0;
`endif
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
`ifdef RISAC_IFETCH_ALIGN_CHECK_EN
            halt_q     <= halt_d;
`endif
        end
    end

    risac_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_risac_ifetch.sv
// -----------------------------------------------------------------------------
// tb_risac_ifetch
// Self-checking bench for risac_ifetch (XLEN=32, DEPTH=4, RESET_PC=0).
// A transaction-level model (a queue of expected entries plus the expected
// fetch address, pending target and halt flag) predicts every output cycle.
// Honors RISAC_IFETCH_ALIGN_CHECK_EN for the alignment-fault scenarios.
// -----------------------------------------------------------------------------
module tb_risac_ifetch;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef RISAC_IFETCH_ALIGN_CHECK_EN
    localparam bit          ALIGN_EN = 1'b1;
`else
    localparam bit          ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] oIbusAddr;
    logic        oIbusRead;
    logic [31:0] iIbusData;
    logic        iIbusWait;
    logic [31:0] oInstr;
    logic [31:0] oInstrPc;
    logic        oInstrFault;
    logic        oInstrValid;
    logic        iInstrReady;
    logic        iRedirect;
    logic [31:0] iRedirectPc;

    logic [31:0] memXor;

    always #5 clk = ~clk;

    // Memory model: the word at an address is the address xor a pattern.
    assign iIbusData = oIbusAddr ^ memXor;

    risac_ifetch #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .oIbusAddr   (oIbusAddr),
        .oIbusRead   (oIbusRead),
        .iIbusData   (iIbusData),
        .iIbusWait   (iIbusWait),
        .oInstr      (oInstr),
        .oInstrPc    (oInstrPc),
        .oInstrFault (oInstrFault),
        .oInstrValid (oInstrValid),
        .iInstrReady (iInstrReady),
        .iRedirect   (iRedirect),
        .iRedirectPc (iRedirectPc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    entry_t      modelQ[$];
    logic [31:0] modelAddr;
    bit          modelPend;
    logic [31:0] modelPendPc;
    bit          modelHalt;

    int assertCount = 0;
    int failCount   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit modelRead();
        return (modelQ.size() < DEPTH) && !modelHalt;
    endfunction

    function automatic void modelReset();
        modelQ.delete();
        modelAddr   = RESET_PC;
        modelPend   = 1'b0;
        modelPendPc = '0;
        modelHalt   = 1'b0;
    endfunction

    function automatic void modelApply(input logic [31:0] t);
        modelQ.delete();
        modelPend = 1'b0;
        modelAddr = {t[31:2], 2'b00};
        modelHalt = 1'b0;
        if (ALIGN_EN && t[1:0] != 2'b00) begin
            modelQ.push_back('{t, 32'h0, 1'b1});
            modelHalt = 1'b1;
        end
    endfunction

    function automatic void modelStep();
        bit rd;
        bit stall;
        bit done;
        bit popped;
        rd     = modelRead();
        stall  = rd && iIbusWait;
        done   = rd && !iIbusWait;
        popped = (modelQ.size() > 0) && iInstrReady;
        if (iRedirect && !stall) begin
            modelApply(iRedirectPc);
        end else begin
            if (iRedirect) begin
                modelPend   = 1'b1;
                modelPendPc = iRedirectPc;
            end
            if (done && modelPend) begin
                modelApply(modelPendPc);
            end else begin
                if (popped) void'(modelQ.pop_front());
                if (done) begin
                    modelQ.push_back('{modelAddr, modelAddr ^ memXor, 1'b0});
                    modelAddr = modelAddr + 32'd4;
                end
            end
        end
    endfunction

    task automatic checkOutput();
        check("ibus_read", 32'(oIbusRead), 32'(modelRead()));
        check("ibus_addr", oIbusAddr, modelAddr);
        check("instr_valid", 32'(oInstrValid), 32'(modelQ.size() > 0));
        if (modelQ.size() > 0) begin
            check("instr_pc", oInstrPc, modelQ[0].pc);
            check("instr_word", oInstr, modelQ[0].instr);
            check("instr_fault", 32'(oInstrFault), 32'(modelQ[0].fault));
        end
    endtask

    // Called at a falling edge: drive, check, advance the model, clock once.
    task automatic applyStimulus(input bit ready, input bit waitReq,
                                 input bit redir, input logic [31:0] rpc);
        iInstrReady = ready;
        iIbusWait   = waitReq;
        iRedirect   = redir;
        iRedirectPc = rpc;
        #1;
        checkOutput();
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n       = 1'b0;
        iInstrReady = 1'b1;
        iIbusWait   = 1'b0;
        iRedirect   = 1'b0;
        iRedirectPc = '0;
        #1;
        modelReset();
        check("reset_read", 32'(oIbusRead), 32'd1);
        check("reset_addr", oIbusAddr, RESET_PC);
        check("reset_valid", 32'(oInstrValid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("reset_hold_valid", 32'(oInstrValid), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b1;
        memXor      = 32'h0;
        iInstrReady = 1'b0;
        iIbusWait   = 1'b0;
        iRedirect   = 1'b0;
        iRedirectPc = '0;
        modelReset();
        @(negedge clk);

        // Streaming: word = address, one entry per cycle after the first.
        $display("[TB] streaming fetch");
        doReset();
        for (int k = 0; k < 8; k++) begin
            if (k >= 1) begin
                check("stream_pc", oInstrPc, 32'((k - 1) * 4));
                check("stream_word", oInstr, 32'((k - 1) * 4));
            end
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        end

        // Fill to full with no consumer, then free exactly one slot.
        $display("[TB] full buffer");
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        check("full_read", 32'(oIbusRead), 32'd0);
        check("full_addr", oIbusAddr, 32'h10);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check("refill_read", 32'(oIbusRead), 32'd1);
        check("refill_addr", oIbusAddr, 32'h10);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // Three-cycle wait at 0x8.
        $display("[TB] bus stall");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            check("stall_addr", oIbusAddr, 32'h8);
            check("stall_read", 32'(oIbusRead), 32'd1);
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        end
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect with three entries buffered and a pop in the same cycle.
        $display("[TB] redirect flush");
        doReset();
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h100);
        check("flush_valid", 32'(oInstrValid), 32'd0);
        check("flush_addr", oIbusAddr, 32'h100);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        check("flush_head_pc", oInstrPc, 32'h100);

        // Redirect while stalled at 0x20; the stalled word is dropped.
        $display("[TB] redirect during stall");
        doReset();
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check("pend_start_addr", oIbusAddr, 32'h20);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
        check("pend_hold_addr", oIbusAddr, 32'h20);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check("pend_addr", oIbusAddr, 32'h200);
        check("pend_valid", 32'(oInstrValid), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check("pend_head_pc", oInstrPc, 32'h200);

        // Misaligned redirect target.
        $display("[TB] misaligned redirect");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h102);
`ifdef RISAC_IFETCH_ALIGN_CHECK_EN
        check("fault_valid", 32'(oInstrValid), 32'd1);
        check("fault_pc", oInstrPc, 32'h102);
        check("fault_flag", 32'(oInstrFault), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("halt_read", 32'(oIbusRead), 32'd0);
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check("halt_after_pop_read", 32'(oIbusRead), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h104);
        check("resume_read", 32'(oIbusRead), 32'd1);
        check("resume_addr", oIbusAddr, 32'h104);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check("resume_pc", oInstrPc, 32'h104);
        check("resume_fault", 32'(oInstrFault), 32'd0);
`else
        check("noalign_addr", oIbusAddr, 32'h100);
        check("noalign_read", 32'(oIbusRead), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        check("noalign_pc", oInstrPc, 32'h100);
        check("noalign_fault", 32'(oInstrFault), 32'd0);
`endif

        // Address wrap at the top of the address space.
        $display("[TB] address wrap");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check("wrap_addr", oIbusAddr, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        // Randomized traffic, including a reset in the middle of a request.
        $display("[TB] random traffic");
        memXor = 32'hC3A5_0000;
        doReset();
        for (int i = 0; i < 400; i++) begin
            bit          rdy;
            bit          wt;
            bit          rd;
            logic [31:0] pc;
            rdy = ($urandom_range(0, 9) < 7);
            wt  = ($urandom_range(0, 9) < 3);
            rd  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else                           pc = $urandom & 32'h0000_FFFF;
            if (ALIGN_EN && $urandom_range(0, 3) != 0) pc = pc & 32'hFFFF_FFFC;
            if (i == 200) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
                doReset();
            end
            applyStimulus(rdy, wt, rd, pc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
